// File: rtl/legv8_lsu.sv
// legv8_lsu: load/store unit between the MEM stage and a 64-bit big-endian
// data memory. One request in flight; loads are sized and extended, partial
// stores run read-modify-write, dword stores write directly.
// Optional macro LEGV8_LSU_FAULT_CHECK_EN: reject requests whose 8-byte
// access would run past MEM_BYTES with resp_fault=1 and no memory access.
module legv8_lsu #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] mem_address,
    output logic [63:0] mem_WD,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    input  logic [63:0] mem_RD
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_e;

    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

    state_e      state_q, state_d;
    logic [63:0] addr_q,  addr_d;
    logic [1:0]  size_q,  size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] buf_q,   buf_d;
    logic        fault_q, fault_d;

    logic        req_fault;
    logic [63:0] load_data;
    logic [63:0] merge_data;

`ifdef LEGV8_LSU_FAULT_CHECK_EN
    assign req_fault = (req_addr > LAST_ADDR);
`else
    logic unused_last_addr;
    assign unused_last_addr = ^LAST_ADDR;
    assign req_fault = 1'b0;
`endif

    // Request/state registers; reset aborts any access in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            buf_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state logic and request capture.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        fault_d  = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
                    fault_d  = req_fault;
                    if (req_fault)
                        state_d = S_RESP;
                    else if (req_write && (req_size == 2'b11))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                buf_d   = mem_RD;
                state_d = write_q ? S_WR : S_RESP;
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Load field extraction: the addressed byte sits in buf[63:56].
    always_comb begin
        load_data = '0;
        unique case (size_q)
            2'b00: load_data = {{56{signed_q & buf_q[63]}}, buf_q[63:56]};
            2'b01: load_data = {{48{signed_q & buf_q[63]}}, buf_q[63:48]};
            2'b10: load_data = {{32{signed_q & buf_q[63]}}, buf_q[63:32]};
            default: load_data = buf_q;
        endcase
    end

    // Store merge: new bytes replace the top of the read-back word.
    always_comb begin
        merge_data = '0;
        unique case (size_q)
            2'b00: merge_data = {wdata_q[7:0],  buf_q[55:0]};
            2'b01: merge_data = {wdata_q[15:0], buf_q[47:0]};
            2'b10: merge_data = {wdata_q[31:0], buf_q[31:0]};
            default: merge_data = wdata_q;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        req_ready    = (state_q == S_IDLE);
        mem_MemRead  = (state_q == S_RD);
        mem_MemWrite = (state_q == S_WR);
        mem_address  = (state_q == S_IDLE) ? '0 : addr_q;
        mem_WD       = (state_q == S_WR) ? merge_data : '0;
        resp_valid   = (state_q == S_RESP);
        resp_fault   = (state_q == S_RESP) && fault_q;
        resp_rdata   = ((state_q == S_RESP) && !write_q && !fault_q) ? load_data : '0;
    end

endmodule

// File: tb/tb_legv8_lsu.sv
// tb_legv8_lsu: directed table-driven bench for legv8_lsu with a byte-array
// big-endian memory model, plus a hand-written mid-operation reset sequence.
module tb_legv8_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_address;
    logic [63:0] mem_WD;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [63:0] mem_RD;

    int checks = 0;
    int errors = 0;

    legv8_lsu #(.MEM_BYTES(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_address  (mem_address),
        .mem_WD       (mem_WD),
        .mem_MemRead  (mem_MemRead),
        .mem_MemWrite (mem_MemWrite),
        .mem_RD       (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 256 bytes, big-endian 8-byte window at mem_address.
    logic [7:0] mem [0:255];
    logic       mem_init;

    always_comb begin
        mem_RD = '0;
        if (mem_MemRead && (mem_address <= 64'd248)) begin
            for (int unsigned i = 0; i < 8; i++)
                mem_RD[63 - 8*i -: 8] = mem[int'(mem_address[7:0]) + int'(i)];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int unsigned i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0] <= 8'hF0; mem[1] <= 8'h11; mem[2] <= 8'h22; mem[3] <= 8'h33;
            mem[4] <= 8'h44; mem[5] <= 8'h55; mem[6] <= 8'h66; mem[7] <= 8'h77;
        end else if (mem_MemWrite && (mem_address <= 64'd248)) begin
            for (int unsigned i = 0; i < 8; i++)
                mem[int'(mem_address[7:0]) + int'(i)] <= mem_WD[63 - 8*i -: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [63:0] exp_wd;
    } vec_t;

    vec_t vecs [0:31];
    int   nvec = 0;

    task automatic add(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] er, input logic ef, input int lat,
                       input int rd, input int wr, input logic [63:0] ewd);
        vecs[nvec].write     = w;
        vecs[nvec].size      = sz;
        vecs[nvec].sgn       = sg;
        vecs[nvec].addr      = a;
        vecs[nvec].wdata     = wd;
        vecs[nvec].exp_rdata = er;
        vecs[nvec].exp_fault = ef;
        vecs[nvec].exp_lat   = lat;
        vecs[nvec].exp_rd    = rd;
        vecs[nvec].exp_wr    = wr;
        vecs[nvec].exp_wd    = ewd;
        nvec++;
    endtask

    // Issue one request (called at posedge+1) and check its full timeline.
    task automatic run_vec(input vec_t v);
        int          cyc;
        int          rd_cnt;
        int          wr_cnt;
        logic [63:0] wd_seen;
        logic [63:0] addr_seen;
        logic        done;
        check("ready_before_req", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = v.write;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = 64'hDEAD_BEEF_DEAD_BEEF;
        req_wdata  = 64'h5555_5555_5555_5555;
        req_size   = ~v.size;
        req_signed = ~v.sgn;
        cyc = 1; rd_cnt = 0; wr_cnt = 0; wd_seen = '0; addr_seen = '0; done = 1'b0;
        while (!done && cyc <= 8) begin
            check("rd_wr_exclusive", 64'(mem_MemRead & mem_MemWrite), 64'd0);
            if (mem_MemRead || mem_MemWrite) addr_seen = mem_address;
            if (mem_MemRead)  rd_cnt++;
            if (mem_MemWrite) begin
                wr_cnt++;
                wd_seen = mem_WD;
            end
            if (resp_valid) begin
                done = 1'b1;
            end else begin
                check("busy_not_ready", 64'(req_ready), 64'd0);
                check("idle_rdata_zero", resp_rdata | 64'(resp_fault), 64'd0);
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check("resp_latency", 64'(cyc), 64'(v.exp_lat));
        check("resp_rdata", resp_rdata, v.exp_rdata);
        check("resp_fault", 64'(resp_fault), 64'(v.exp_fault));
        check("read_cycles", 64'(rd_cnt), 64'(v.exp_rd));
        check("write_cycles", 64'(wr_cnt), 64'(v.exp_wr));
        if (v.exp_wr != 0) check("mem_WD", wd_seen, v.exp_wd);
        if (v.exp_rd + v.exp_wr != 0) check("mem_address", addr_seen, v.addr);
        @(posedge clk);
        #1;
        check("ready_after_resp", 64'(req_ready), 64'd1);
        check("resp_one_cycle", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   waited;
        rst = 1'b0; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;

        // Directed vectors: memory starts F0 11 22 33 44 55 66 77, rest zero.
        //   write sz sgn addr    wdata                   exp_rdata               flt lat rd wr exp_wd
        add(1'b0, 2'd3, 1'b0, 64'd0,   64'd0,                  64'hF011_2233_4455_6677, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd0, 1'b1, 64'd0,   64'd0,                  64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd0, 1'b0, 64'd0,   64'd0,                  64'h0000_0000_0000_00F0, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd2, 1'b1, 64'd4,   64'd0,                  64'h0000_0000_4455_6677, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd1, 1'b1, 64'd0,   64'd0,                  64'hFFFF_FFFF_FFFF_F011, 1'b0, 2, 1, 0, 64'd0);
        // byte store at 1 reads bytes 1..8 (11 22 .. 77 00) and replaces the first
        add(1'b1, 2'd0, 1'b0, 64'd1,   64'h0000_0000_0000_00AB, 64'd0,                  1'b0, 3, 1, 1, 64'hAB22_3344_5566_7700);
        add(1'b0, 2'd3, 1'b0, 64'd0,   64'd0,                  64'hF0AB_2233_4455_6677, 1'b0, 2, 1, 0, 64'd0);
        add(1'b1, 2'd3, 1'b0, 64'd8,   64'h0123_4567_89AB_CDEF, 64'd0,                  1'b0, 2, 0, 1, 64'h0123_4567_89AB_CDEF);
        add(1'b0, 2'd3, 1'b1, 64'd8,   64'd0,                  64'h0123_4567_89AB_CDEF, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd0, 1'b1, 64'd9,   64'd0,                  64'h0000_0000_0000_0023, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd0, 1'b1, 64'd12,  64'd0,                  64'hFFFF_FFFF_FFFF_FF89, 1'b0, 2, 1, 0, 64'd0);
        add(1'b1, 2'd1, 1'b1, 64'd16,  64'h1111_2222_3333_CAFE, 64'd0,                  1'b0, 3, 1, 1, 64'hCAFE_0000_0000_0000);
        add(1'b0, 2'd1, 1'b0, 64'd16,  64'd0,                  64'h0000_0000_0000_CAFE, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd1, 1'b1, 64'd16,  64'd0,                  64'hFFFF_FFFF_FFFF_CAFE, 1'b0, 2, 1, 0, 64'd0);
        add(1'b1, 2'd2, 1'b0, 64'd20,  64'hFFFF_FFFF_89AB_CDEF, 64'd0,                  1'b0, 3, 1, 1, 64'h89AB_CDEF_0000_0000);
        add(1'b0, 2'd3, 1'b0, 64'd16,  64'd0,                  64'hCAFE_0000_89AB_CDEF, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd2, 1'b1, 64'd20,  64'd0,                  64'hFFFF_FFFF_89AB_CDEF, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd2, 1'b0, 64'd20,  64'd0,                  64'h0000_0000_89AB_CDEF, 1'b0, 2, 1, 0, 64'd0);
        add(1'b0, 2'd3, 1'b0, 64'd248, 64'd0,                  64'd0,                  1'b0, 2, 1, 0, 64'd0);
`ifdef LEGV8_LSU_FAULT_CHECK_EN
        add(1'b0, 2'd0, 1'b1, 64'd249, 64'd0,                  64'd0,                  1'b1, 1, 0, 0, 64'd0);
        add(1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1, 0, 0, 64'd0);
        add(1'b0, 2'd3, 1'b0, 64'd0,   64'd0,                  64'hF0AB_2233_4455_6677, 1'b0, 2, 1, 0, 64'd0);
`endif

        // Reset state.
        #12;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_outputs", resp_rdata | mem_address | mem_WD, 64'd0);
        check("rst_mem_ctl", {62'd0, mem_MemRead, mem_MemWrite} | 64'(resp_fault), 64'd0);
        @(posedge clk);
        #3;
        mem_init = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < nvec; i++) begin
            v = vecs[i];
            run_vec(v);
        end

        // Reset during the write cycle of a partial store.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 64'd32; req_wdata = 64'h0000_0000_0000_005A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waited = 0;
        while (!mem_MemWrite && waited < 6) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("abort_reached_wr", 64'(mem_MemWrite), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_memwrite_drop", 64'(mem_MemWrite), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_no_resp", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_late_resp", 64'(resp_valid), 64'd0);
        end
        v.write = 1'b0; v.size = 2'd3; v.sgn = 1'b0; v.addr = 64'd32; v.wdata = '0;
        v.exp_rdata = 64'd0; v.exp_fault = 1'b0; v.exp_lat = 2; v.exp_rd = 1; v.exp_wr = 0; v.exp_wd = '0;
        run_vec(v);
        v.addr = 64'd0; v.exp_rdata = 64'hF0AB_2233_4455_6677;
        run_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
